output_port_tx: RTL and testbench

//  Transmit side of a router output port; drives flits into the downstream router's input buffer.

---
 rtl/noc_pkg.sv | 32 +++
 rtl/output_port_tx_if.sv | 26 ++
 rtl/output_port_tx_vc_credit_ctr.sv | 49 ++++
 rtl/output_port_tx.sv | 195 +++++++++++++++++++
 tb/tb_output_port_tx.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, type-field position and output-port defaults.
package noc_pkg;

    localparam int FLIT_W        = 64;
    localparam int NUM_VC        = 2;
    localparam int VC_DEPTH      = 4;
    localparam int VC_W          = 2;
    localparam int FLIT_TYPE_MSB = 47;
    localparam int FLIT_TYPE_LSB = 45;

    typedef enum logic [2:0] {
        FLIT_HEAD     = 3'b000,
        FLIT_BODY     = 3'b001,
        FLIT_TAIL     = 3'b010,
        FLIT_HEADTAIL = 3'b011
    } flit_type_e;

    typedef enum logic {
        VC_IDLE   = 1'b0,
        VC_ACTIVE = 1'b1
    } vc_state_e;

    function automatic logic is_head(input logic [2:0] ftype);
        return (ftype == FLIT_HEAD) || (ftype == FLIT_HEADTAIL);
    endfunction

    // Unused codes 1xx fall through as body flits: neither head nor tail.
    function automatic logic is_tail(input logic [2:0] ftype);
        return (ftype == FLIT_TAIL) || (ftype == FLIT_HEADTAIL);
    endfunction

endpackage

// File: rtl/output_port_tx_if.sv
// Crossbar-side, credit-return and link-side signals of one router output port.
interface output_port_tx_if;
    import noc_pkg::*;

    logic [FLIT_W-1:0] xb_flit_in;
    logic              xb_valid;
    logic [VC_W-1:0]   xb_vc;
    logic              xb_ready;
    logic              credit_valid;
    logic [VC_W-1:0]   credit_vc;
    logic [FLIT_W-1:0] dataOut;
    logic              dataOut_valid;
    logic [VC_W-1:0]   dataOut_vc;

    // master: crossbar + downstream router side; slave: the output port itself.
    modport master (
        output xb_flit_in, xb_valid, xb_vc, credit_valid, credit_vc,
        input  xb_ready, dataOut, dataOut_valid, dataOut_vc
    );

    modport slave (
        input  xb_flit_in, xb_valid, xb_vc, credit_valid, credit_vc,
        output xb_ready, dataOut, dataOut_valid, dataOut_vc
    );

endinterface

// File: rtl/output_port_tx_vc_credit_ctr.sv
// Credit counter for one downstream VC: saturates at 0 and DEPTH, inc+dec together holds.
module vc_credit_ctr #(
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          has_credit,
    output logic          overflow
);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= CW'(DEPTH);
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        overflow = 1'b0;
        unique case ({inc, dec})
            2'b10: begin
                if (cnt_reg == CW'(DEPTH)) begin
                    overflow = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            2'b01: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: cnt_next = cnt_reg;
        endcase
    end

    assign cnt        = cnt_reg;
    assign has_credit = (cnt_reg != '0);

endmodule

// File: rtl/output_port_tx.sv
// Router output port transmitter: per-packet downstream VC allocation, credit flow control,
// registered link output. Define OUTPORT_STATS_EN to add stat_flits/stat_stalls counters.
module output_port_tx
    import noc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    output_port_tx_if.slave      io,
    output logic [NUM_VC-1:0]    vc_busy,
    output logic                 proto_err
`ifdef OUTPORT_STATS_EN
    ,
    output logic [31:0]          stat_flits,
    output logic [31:0]          stat_stalls
`endif
);

    localparam int CW = $clog2(VC_DEPTH + 1);

    logic [2:0]                   flit_type;
    logic                         head_flit;
    logic                         tail_flit;

    logic [NUM_VC-1:0]            idle_vec;
    logic [NUM_VC-1:0]            active_vec;
    logic [NUM_VC-1:0]            has_credit;
    logic [NUM_VC-1:0]            overflow;
    logic [NUM_VC-1:0]            inc;
    logic [NUM_VC-1:0]            dec;
    logic [NUM_VC-1:0][VC_W-1:0]  owner_vec;
    logic [NUM_VC-1:0][CW-1:0]    cnt_vec;

    logic                         head_found;
    logic [VC_W-1:0]              head_vc;
    logic                         match_found;
    logic [VC_W-1:0]              match_vc;
    logic                         match_credit;
    logic [VC_W-1:0]              target_vc;

    logic                         ready;
    logic                         accept;
    logic                         send;
    logic                         orphan;

    logic [FLIT_W-1:0]            data_reg;
    logic                         valid_reg;
    logic [VC_W-1:0]              vc_reg;
    logic                         err_reg;

    always_comb begin
        flit_type = io.xb_flit_in[FLIT_TYPE_MSB:FLIT_TYPE_LSB];
        head_flit = is_head(flit_type);
        tail_flit = is_tail(flit_type);
    end

    // Descending scan so the lowest-index free VC with credit wins.
    always_comb begin
        head_found = 1'b0;
        head_vc    = '0;
        for (int v = NUM_VC - 1; v >= 0; v--) begin
            if (idle_vec[v] && has_credit[v]) begin
                head_found = 1'b1;
                head_vc    = VC_W'(v);
            end
        end
    end

    // At most one ACTIVE VC can be owned by a given upstream VC.
    always_comb begin
        match_found  = 1'b0;
        match_vc     = '0;
        match_credit = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (active_vec[v] && (owner_vec[v] == io.xb_vc)) begin
                match_found  = 1'b1;
                match_vc     = VC_W'(v);
                match_credit = (cnt_vec[v] != '0);
            end
        end
    end

    // Orphan body/tail flits are accepted so they cannot block the crossbar.
    always_comb begin
        ready     = 1'b1;
        target_vc = match_vc;
        if (head_flit) begin
            ready     = head_found;
            target_vc = head_vc;
        end else if (match_found) begin
            ready     = match_credit;
        end
        accept = io.xb_valid && ready;
        send   = accept && (head_flit || match_found);
        orphan = accept && !head_flit && !match_found;
    end

    assign io.xb_ready = ready;

    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
        vc_state_e       state_reg;
        vc_state_e       state_next;
        logic [VC_W-1:0] owner_reg;
        logic [VC_W-1:0] owner_next;

        assign inc[gi] = io.credit_valid && (io.credit_vc == VC_W'(gi));
        assign dec[gi] = send && (target_vc == VC_W'(gi));

        vc_credit_ctr #(
            .DEPTH      (VC_DEPTH)
        ) u_credit (
            .clk        (clk),
            .rst        (rst),
            .inc        (inc[gi]),
            .dec        (dec[gi]),
            .cnt        (cnt_vec[gi]),
            .has_credit (has_credit[gi]),
            .overflow   (overflow[gi])
        );

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_reg <= VC_IDLE;
                owner_reg <= '0;
            end else begin
                state_reg <= state_next;
                owner_reg <= owner_next;
            end
        end

        // Tail check first: a head+tail flit claims and frees the VC in one cycle.
        always_comb begin
            state_next = state_reg;
            owner_next = owner_reg;
            if (dec[gi]) begin
                if (tail_flit) begin
                    state_next = VC_IDLE;
                end else if (head_flit) begin
                    state_next = VC_ACTIVE;
                    owner_next = io.xb_vc;
                end
            end
        end

        assign idle_vec[gi]   = (state_reg == VC_IDLE);
        assign active_vec[gi] = (state_reg == VC_ACTIVE);
        assign owner_vec[gi]  = owner_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            vc_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            valid_reg <= send;
            if (send) begin
                data_reg <= io.xb_flit_in;
                vc_reg   <= target_vc;
            end
            if (orphan || (|overflow)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign io.dataOut       = data_reg;
    assign io.dataOut_valid = valid_reg;
    assign io.dataOut_vc    = vc_reg;
    assign vc_busy          = active_vec;
    assign proto_err        = err_reg;

`ifdef OUTPORT_STATS_EN
    logic [31:0] flits_reg;
    logic [31:0] stalls_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flits_reg  <= '0;
            stalls_reg <= '0;
        end else begin
            if (accept) begin
                flits_reg <= flits_reg + 32'd1;
            end
            if (io.xb_valid && !ready) begin
                stalls_reg <= stalls_reg + 32'd1;
            end
        end
    end

    assign stat_flits  = flits_reg;
    assign stat_stalls = stalls_reg;
`endif

endmodule

// File: tb/tb_output_port_tx.sv
// Directed, table-driven bench for output_port_tx; stats checks compile in with OUTPORT_STATS_EN.
module tb_output_port_tx;
    import noc_pkg::*;

    localparam logic [2:0] H  = 3'b000;
    localparam logic [2:0] B  = 3'b001;
    localparam logic [2:0] T  = 3'b010;
    localparam logic [2:0] HT = 3'b011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_port_tx_if io();
    logic [1:0] vc_busy;
    logic       proto_err;
`ifdef OUTPORT_STATS_EN
    logic [31:0] stat_flits;
    logic [31:0] stat_stalls;
`endif

    output_port_tx dut (
        .clk         (clk),
        .rst         (rst_n),
        .io          (io),
        .vc_busy     (vc_busy),
        .proto_err   (proto_err)
`ifdef OUTPORT_STATS_EN
        ,
        .stat_flits  (stat_flits),
        .stat_stalls (stat_stalls)
`endif
    );

    typedef struct {
        bit         rst;    // pulse reset mid-cycle before this vector
        bit         v;
        logic [2:0] ft;
        logic [1:0] vc;
        bit         cv;
        logic [1:0] cvc;
        bit         er;     // expected xb_ready
        bit         eov;    // expected dataOut_valid after the edge
        logic [1:0] eovc;
        logic [1:0] ebusy;
        bit         eerr;
    } vec_t;

    vec_t        tbl[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_flit;
    int          exp_flits;
    int          exp_stalls;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit v, input logic [2:0] ft, input logic [1:0] vc,
                       input bit cv, input logic [1:0] cvc, input bit er, input bit eov,
                       input logic [1:0] eovc, input logic [1:0] ebusy, input bit eerr);
        vec_t t;
        t = '{r, v, ft, vc, cv, cvc, er, eov, eovc, ebusy, eerr};
        tbl.push_back(t);
    endtask

    task automatic drive_idle();
        io.xb_flit_in   = '0;
        io.xb_valid     = 1'b0;
        io.xb_vc        = '0;
        io.credit_valid = 1'b0;
        io.credit_vc    = '0;
    endtask

    task automatic check_stats(input int idx);
`ifdef OUTPORT_STATS_EN
        chk($sformatf("v%0d stat_flits", idx), 64'(stat_flits), 64'(exp_flits));
        chk($sformatf("v%0d stat_stalls", idx), 64'(stat_stalls), 64'(exp_stalls));
`else
        if (idx < 0) $display("bad index %0d", idx);
`endif
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for an edge.
    task automatic apply_reset(input int idx);
        check_stats(idx);
        drive_idle();
        rst_n = 1'b0;
        #1;
        chk($sformatf("v%0d rst dataOut_valid", idx), 64'(io.dataOut_valid), 64'd0);
        chk($sformatf("v%0d rst dataOut_vc", idx), 64'(io.dataOut_vc), 64'd0);
        chk($sformatf("v%0d rst dataOut", idx), io.dataOut, 64'd0);
        chk($sformatf("v%0d rst vc_busy", idx), 64'(vc_busy), 64'd0);
        chk($sformatf("v%0d rst proto_err", idx), 64'(proto_err), 64'd0);
        last_flit  = '0;
        exp_flits  = 0;
        exp_stalls = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        vec_t        t;
        logic [63:0] flit;

        // A: head/body/body/tail from xb_vc 1 on VC0; then VC0 has no credit left
        add(1, 1, H,  1, 0, 0, 1, 1, 0, 2'b01, 0);
        add(0, 1, B,  1, 0, 0, 1, 1, 0, 2'b01, 0);
        add(0, 1, B,  1, 0, 0, 1, 1, 0, 2'b01, 0);
        add(0, 1, T,  1, 0, 0, 1, 1, 0, 2'b00, 0);
        add(0, 1, H,  0, 0, 0, 1, 1, 1, 2'b10, 0);
        add(0, 0, H,  0, 0, 0, 0, 0, 0, 2'b10, 0);
        // B: five flits into VC0, 5th stalls until a credit comes back
        add(1, 1, H,  0, 0, 0, 1, 1, 0, 2'b01, 0);
        add(0, 1, B,  0, 0, 0, 1, 1, 0, 2'b01, 0);
        add(0, 1, B,  0, 0, 0, 1, 1, 0, 2'b01, 0);
        add(0, 1, B,  0, 0, 0, 1, 1, 0, 2'b01, 0);
        add(0, 1, B,  0, 0, 0, 0, 0, 0, 2'b01, 0);
        add(0, 1, B,  0, 1, 0, 0, 0, 0, 2'b01, 0);
        add(0, 1, B,  0, 0, 0, 1, 1, 0, 2'b01, 0);
        // C: interleaved packets, then VC0 re-granted right after its tail
        add(1, 1, H,  0, 0, 0, 1, 1, 0, 2'b01, 0);
        add(0, 1, H,  1, 0, 0, 1, 1, 1, 2'b11, 0);
        add(0, 1, B,  0, 0, 0, 1, 1, 0, 2'b11, 0);
        add(0, 1, B,  1, 0, 0, 1, 1, 1, 2'b11, 0);
        add(0, 1, T,  0, 0, 0, 1, 1, 0, 2'b10, 0);
        add(0, 1, H,  0, 0, 0, 1, 1, 0, 2'b11, 0);
        add(0, 1, T,  1, 0, 0, 1, 1, 1, 2'b01, 0);
        // D: send+credit at 2 holds; credit at 4 saturates and flags error
        add(1, 1, H,  0, 0, 0, 1, 1, 0, 2'b01, 0);
        add(0, 1, B,  0, 0, 0, 1, 1, 0, 2'b01, 0);
        add(0, 1, B,  0, 1, 0, 1, 1, 0, 2'b01, 0);
        add(0, 1, B,  0, 0, 0, 1, 1, 0, 2'b01, 0);
        add(0, 1, B,  0, 0, 0, 1, 1, 0, 2'b01, 0);
        add(0, 1, B,  0, 0, 0, 0, 0, 0, 2'b01, 0);
        add(0, 0, B,  0, 1, 1, 0, 0, 0, 2'b01, 1);
        add(0, 1, HT, 1, 0, 0, 1, 1, 1, 2'b01, 1);
        add(0, 1, HT, 1, 0, 0, 1, 1, 1, 2'b01, 1);
        add(0, 1, HT, 1, 0, 0, 1, 1, 1, 2'b01, 1);
        add(0, 1, HT, 1, 0, 0, 1, 1, 1, 2'b01, 1);
        add(0, 1, HT, 1, 0, 0, 0, 0, 0, 2'b01, 1);
        // E: orphan body dropped; head+tail leaves VC idle; open a packet
        add(1, 1, B,  0, 0, 0, 1, 0, 0, 2'b00, 1);
        add(0, 1, HT, 1, 0, 0, 1, 1, 0, 2'b00, 1);
        add(0, 1, H,  0, 0, 0, 1, 1, 0, 2'b01, 1);
        add(0, 1, B,  0, 0, 0, 1, 1, 0, 2'b01, 1);
        // F: reset mid-packet; VC0 must hold exactly 4 credits again
        add(1, 1, HT, 0, 0, 0, 1, 1, 0, 2'b00, 0);
        add(0, 1, HT, 0, 0, 0, 1, 1, 0, 2'b00, 0);
        add(0, 1, HT, 0, 0, 0, 1, 1, 0, 2'b00, 0);
        add(0, 1, HT, 0, 0, 0, 1, 1, 0, 2'b00, 0);
        add(0, 1, HT, 0, 0, 0, 1, 1, 1, 2'b00, 0);

        last_flit  = '0;
        exp_flits  = 0;
        exp_stalls = 0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            if (t.rst) apply_reset(i);
            flit = {16'hA5A5, t.ft, 45'(i)};
            io.xb_flit_in   = flit;
            io.xb_valid     = t.v;
            io.xb_vc        = t.vc;
            io.credit_valid = t.cv;
            io.credit_vc    = t.cvc;
            #1;
            chk($sformatf("v%0d xb_ready", i), 64'(io.xb_ready), 64'(t.er));
            if (t.v) begin
                if (t.er) exp_flits++;
                else      exp_stalls++;
            end
            @(posedge clk);
            #1;
            if (t.eov) last_flit = flit;
            chk($sformatf("v%0d dataOut_valid", i), 64'(io.dataOut_valid), 64'(t.eov));
            if (t.eov) chk($sformatf("v%0d dataOut_vc", i), 64'(io.dataOut_vc), 64'(t.eovc));
            chk($sformatf("v%0d dataOut", i), io.dataOut, last_flit);
            chk($sformatf("v%0d vc_busy", i), 64'(vc_busy), 64'(t.ebusy));
            chk($sformatf("v%0d proto_err", i), 64'(proto_err), 64'(t.eerr));
            $display("vec %0d: rst=%0b valid=%0b type=%0d vc=%0d credit=%0b/%0d -> ready=%0b out_valid=%0b out_vc=%0d busy=%b err=%0b",
                     i, t.rst, t.v, t.ft, t.vc, t.cv, t.cvc, io.xb_ready,
                     io.dataOut_valid, io.dataOut_vc, vc_busy, proto_err);
        end

        drive_idle();
        #1;
        check_stats(tbl.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
